// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART sizing constants for receiver, transmitter and FIFOs
package uart_pkg;

    localparam int UART_BYTE_WIDTH    = 8;
    localparam int UART_RX_FIFO_DEPTH = 8;

endpackage : uart_pkg

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read
module uart_fifo_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // Contents are deliberately left unreset; occupancy tracking makes them don't-care.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule : uart_fifo_ram

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word fall-through receive FIFO with sticky overflow flag
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    parameter int WIDTH = UART_BYTE_WIDTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx_valid,
    input  logic [WIDTH-1:0] i_rx_byte,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_overflow,
    input  logic             i_clear_overflow
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic pop;
    logic push;
    logic drop;

    // Status comes only from registered state so o_valid/o_data never depend on inputs.
    assign o_valid    = (count_q != '0);
    assign o_full     = (count_q == FULL_COUNT);
    assign o_count    = count_q;
    assign o_overflow = overflow_q;

    assign pop  = o_valid && i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign push = i_rx_valid && (!o_full || pop);
    assign drop = i_rx_valid && o_full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end

        // Set has priority over clear so a drop is never lost.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (i_clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (push),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_rx_byte),
        .i_raddr (rd_ptr_q),
        .o_rdata (o_data)
    );

endmodule : uart_rx_fifo

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-low; the ports are named i_clk and i_rst_n.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of byte entries; legal values are powers of two from 2 to 256.
REQ-003 Parameter WIDTH, default 8, SHALL set the data width in bits.
REQ-004 i_clk  input  1  SHALL be the single clock; every register updates on its rising edge.
REQ-005 i_rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-006 i_rx_valid  input  1  SHALL be a one-cycle strobe from the UART receiver marking a new byte.
REQ-007 i_rx_byte  input  WIDTH  SHALL be the received byte, sampled only when i_rx_valid=1.
REQ-008 o_valid  output  1  SHALL be 1 whenever the FIFO holds at least one entry.
REQ-009 o_data  output  WIDTH  SHALL be the oldest entry (first-word fall-through); it is defined only when o_valid=1.
REQ-010 i_ready  input  1  SHALL be the consumer's accept signal; a pop occurs when o_valid=1 and i_ready=1.
REQ-011 o_count  output  $clog2(DEPTH)+1  SHALL give the current occupancy, 0..DEPTH.
REQ-012 o_full  output  1  SHALL be 1 when o_count==DEPTH.
REQ-013 o_overflow  output  1  SHALL be a sticky flag marking that a byte was dropped.
REQ-014 i_clear_overflow  input  1  SHALL clear o_overflow synchronously.

Function
REQ-015 A push SHALL occur when i_rx_valid=1 and the FIFO is not full, or when i_rx_valid=1 and a pop occurs in the same cycle.
REQ-016 A byte pushed at edge N SHALL make o_valid=1 and drive o_data after edge N if the FIFO was empty, giving one-cycle latency.
REQ-017 A pop SHALL advance the read pointer; the next entry, if any, SHALL appear on o_data in the following cycle.
REQ-018 i_ready asserted while o_valid=0 SHALL have no effect.
REQ-019 A simultaneous push and pop SHALL leave o_count unchanged, both when the FIFO is full and when it is partially filled.
REQ-020 i_rx_valid=1 while the FIFO is full with no pop SHALL drop the byte, leave storage and o_count unchanged, and set o_overflow at the next edge.
REQ-021 The read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH without any special case.
REQ-022 o_count SHALL be a registered counter: +1 on a push only, -1 on a pop only, and unchanged otherwise.
REQ-023 o_overflow SHALL hold until i_clear_overflow=1; if a clear and a new overflow occur in the same cycle, the set SHALL win.
REQ-024 The block SHALL contain no explicit FSM; its sequential state is the pointers, the count, the storage and the overflow flag.
REQ-025 o_valid, o_full and o_data SHALL be derived combinationally from the registered state only, never from the current-cycle inputs.

Reset
REQ-026 Asserting i_rst_n=0 SHALL asynchronously set the pointers and o_count to 0, o_valid=0, o_full=0 and o_overflow=0.
REQ-027 Storage contents SHALL NOT be reset; o_data is don't-care while o_valid=0.
REQ-028 Reset applied mid-operation SHALL discard all queued bytes, and the first push after release SHALL be the first entry popped.
REQ-029 Reset SHALL be released synchronously to i_clk by the surrounding logic; the block has no internal reset synchronizer.

Structure
REQ-030 Package uart_pkg SHALL hold UART_BYTE_WIDTH=8 and UART_RX_FIFO_DEPTH=8, shared with the receiver and transmitter.
REQ-031 Storage SHALL be the sub-module uart_fifo_ram: a DEPTH x WIDTH array with synchronous write and asynchronous read.
REQ-032 The pointer, count and flag logic SHALL reside in uart_rx_fifo itself.

Verification
REQ-033 Reset, then push 0x41, 0x42, 0x43 on separate cycles with i_ready=0 -> o_count=3, o_data=0x41, then a pop each cycle yields 0x41, 0x42, 0x43 and o_valid=0 after the third pop.
REQ-034 Fill DEPTH=8 entries with 0x00..0x07, then push 0xFF with no pop -> o_full=1, o_count=8, o_overflow=1, and draining yields 0x00..0x07 without 0xFF.
REQ-035 Full FIFO with push 0xAA and pop in the same cycle -> o_count stays 8, o_overflow stays 0, and 0xAA is the last byte drained.
REQ-036 Push and pop continuously for 20 bytes, 0x10..0x23 -> the output order matches the input, and the pointers wrap twice with no loss.
REQ-037 o_overflow=1, then i_clear_overflow=1 in the same cycle as another full-drop -> o_overflow remains 1, and a clear alone on the next cycle gives 0.
REQ-038 Assert i_rst_n=0 mid-cycle with 5 entries queued -> o_valid=0 and o_count=0 immediately, and a push of 0x55 after release is the first byte out.
